// File: rtl/spi_pkg.sv
// Shared SPI frame definitions: opcodes, frame geometry and master FSM states.
package spi_pkg;

   localparam logic [1:0] WR_ADDR = 2'b00;
   localparam logic [1:0] WR_DATA = 2'b01;
   localparam logic [1:0] RD_ADDR = 2'b10;
   localparam logic [1:0] RD_DATA = 2'b11;

   localparam int CMD_CYCLES = 2;
   localparam int WORD_W     = 10;
   localparam int RD_W       = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_SHIFT,
      S_TURN,
      S_RECV,
      S_GAP
   } state_t;

endpackage

// File: rtl/spi_master.sv
// SPI master sharing clk with the slave: serializes 10-bit command words on
// SS_n/MOSI and captures the 8-bit reply on MISO for read-data frames.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | SS_n high, cmd_ready high, waiting for a command handshake
//   S_CMD   | frame cycles 0-1, MOSI holds the command bit word[9]
//   S_SHIFT | frame cycles 2-11, word shifted out MSB first
//   S_TURN  | read-data turnaround, cycles 12 .. MISO_FIRST-1, MOSI low
//   S_RECV  | MISO sampled MSB first for RD_W cycles
//   S_GAP   | SS_n high for GAP cycles before returning to idle
module spi_master
   import spi_pkg::*;
#(
   parameter int MISO_FIRST = 13,
   parameter int GAP        = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [9:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       busy,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO
);

   localparam logic [4:0] CMD_LAST   = 5'(CMD_CYCLES - 1);
   localparam logic [4:0] SHIFT_LAST = 5'(CMD_CYCLES + WORD_W - 1);
   localparam logic [4:0] TURN_LAST  = 5'(MISO_FIRST - 1);
   localparam logic [4:0] RECV_LAST  = 5'(MISO_FIRST + RD_W - 1);
   localparam bit         HAS_TURN   = (MISO_FIRST > CMD_CYCLES + WORD_W);
   localparam int         GAP_W      = (GAP > 1) ? $clog2(GAP) : 1;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [4:0]         r_cnt;
   logic [GAP_W-1:0]   r_gap;
   logic [9:0]         r_tx;
   logic [1:0]         r_op;
   logic [6:0]         r_rx;
   logic               r_rsp_valid;
   logic [7:0]         r_rsp_data;
   logic               w_enter_gap;

   always_comb begin
      w_state_nxt = r_state;
      SS_n        = 1'b1;
      MOSI        = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (cmd_valid) w_state_nxt = S_CMD;
         end
         S_CMD: begin
            SS_n = 1'b0;
            MOSI = r_tx[9];
            if (r_cnt == CMD_LAST) w_state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            SS_n = 1'b0;
            MOSI = r_tx[9];
            if (r_cnt == SHIFT_LAST) begin
               if (r_op == RD_DATA) w_state_nxt = HAS_TURN ? S_TURN : S_RECV;
               else                 w_state_nxt = S_GAP;
            end
         end
         S_TURN: begin
            SS_n = 1'b0;
            if (r_cnt == TURN_LAST) w_state_nxt = S_RECV;
         end
         S_RECV: begin
            SS_n = 1'b0;
            if (r_cnt == RECV_LAST) w_state_nxt = S_GAP;
         end
         S_GAP: begin
            if (r_gap == '0) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_enter_gap = (w_state_nxt == S_GAP) && (r_state != S_GAP);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_gap       <= '0;
         r_tx        <= '0;
         r_op        <= '0;
         r_rx        <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_rsp_valid <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (cmd_valid) begin
                  r_tx <= cmd_data;
                  r_op <= cmd_data[9:8];
               end
            end
            S_SHIFT: begin
               r_cnt <= r_cnt + 5'd1;
               r_tx  <= {r_tx[8:0], 1'b0};
            end
            S_RECV: begin
               r_cnt <= r_cnt + 5'd1;
               r_rx  <= {r_rx[5:0], MISO};
               // Only the completed byte is published; partial shifts stay internal.
               if (r_cnt == RECV_LAST) begin
                  r_rsp_data  <= {r_rx, MISO};
                  r_rsp_valid <= 1'b1;
               end
            end
            S_GAP: begin
               r_cnt <= '0;
            end
            default: begin
               r_cnt <= r_cnt + 5'd1;
            end
         endcase
         if (w_enter_gap)            r_gap <= GAP_W'(GAP - 1);
         else if (r_state == S_GAP)  r_gap <= r_gap - 1'b1;
      end
   end

   assign cmd_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_spi_master.sv
// Randomized frame-level bench for spi_master: two instances (default timing
// and MISO_FIRST=15/GAP=2) checked cycle by cycle against a frame model.
module tb_spi_master;

   localparam int MF_TAB [2] = '{13, 15};
   localparam int GP_TAB [2] = '{1, 2};

   logic       clk;
   logic       rst       [2];
   logic       cmd_valid [2];
   logic [9:0] cmd_data  [2];
   logic       miso      [2];
   logic       cmd_ready [2];
   logic       rsp_valid [2];
   logic [7:0] rsp_data  [2];
   logic       busy      [2];
   logic       ss_n      [2];
   logic       mosi      [2];

   logic [7:0] exp_rsp   [2];
   int         n_chk;
   int         n_pass;

   spi_master #(.MISO_FIRST(13), .GAP(1)) u_dut0 (
      .clk(clk), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_data(cmd_data[0]), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
      .busy(busy[0]), .SS_n(ss_n[0]), .MOSI(mosi[0]), .MISO(miso[0])
   );

   spi_master #(.MISO_FIRST(15), .GAP(2)) u_dut1 (
      .clk(clk), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_data(cmd_data[1]), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
      .busy(busy[1]), .SS_n(ss_n[1]), .MOSI(mosi[1]), .MISO(miso[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic chk_idle(input int d, input string tag);
      chk($sformatf("%s ss_n d%0d", tag, d),      32'(ss_n[d]),      32'd1);
      chk($sformatf("%s mosi d%0d", tag, d),      32'(mosi[d]),      32'd0);
      chk($sformatf("%s ready d%0d", tag, d),     32'(cmd_ready[d]), 32'd1);
      chk($sformatf("%s busy d%0d", tag, d),      32'(busy[d]),      32'd0);
      chk($sformatf("%s rsp_valid d%0d", tag, d), 32'(rsp_valid[d]), 32'd0);
      chk($sformatf("%s rsp_data d%0d", tag, d),  32'(rsp_data[d]),  32'(exp_rsp[d]));
   endtask

   task automatic idle_cycles(input int d, input int n);
      cmd_valid[d] = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk_idle(d, "idle");
      end
   endtask

   // Starts at a negedge of an idle cycle; returns at the negedge of the first
   // idle cycle after the frame. rst_at >= 0 pulses reset in that frame cycle.
   task automatic run_frame(input int d, input logic [9:0] w, input logic [7:0] reply,
                            input bit keep, input bit noise, input int rst_at);
      int  mf;
      int  gp;
      int  len;
      bit  rd;
      bit  e_ss;
      bit  e_mosi;
      bit  e_busy;
      mf  = MF_TAB[d];
      gp  = GP_TAB[d];
      rd  = (w[9:8] == 2'b11);
      len = rd ? mf + 8 : 12;
      cmd_valid[d] = 1'b1;
      cmd_data[d]  = w;
      chk($sformatf("offer ready d%0d", d), 32'(cmd_ready[d]), 32'd1);
      for (int k = 0; k < len + gp; k++) begin
         @(negedge clk);
         if (noise)      cmd_data[d]  = 10'($urandom);
         else if (!keep) cmd_valid[d] = 1'b0;
         if (rd && k == len) exp_rsp[d] = reply;
         e_ss   = (k >= len);
         e_busy = 1'b1;
         if (k < 2)       e_mosi = w[9];
         else if (k < 12) e_mosi = w[11 - k];
         else             e_mosi = 1'b0;
         chk($sformatf("ss_n d%0d w%0h k%0d", d, w, k),      32'(ss_n[d]),      32'(e_ss));
         chk($sformatf("mosi d%0d w%0h k%0d", d, w, k),      32'(mosi[d]),      32'(e_mosi));
         chk($sformatf("busy d%0d w%0h k%0d", d, w, k),      32'(busy[d]),      32'(e_busy));
         chk($sformatf("ready d%0d w%0h k%0d", d, w, k),     32'(cmd_ready[d]), 32'd0);
         chk($sformatf("rsp_valid d%0d w%0h k%0d", d, w, k), 32'(rsp_valid[d]), 32'(rd && k == len));
         chk($sformatf("rsp_data d%0d w%0h k%0d", d, w, k),  32'(rsp_data[d]),  32'(exp_rsp[d]));
         miso[d] = (rd && k >= mf && k < mf + 8) ? reply[7 - (k - mf)] : 1'bx;
         if (k == rst_at) begin
            rst[d] = 1'b1;
            @(negedge clk);
            exp_rsp[d] = 8'h00;
            chk_idle(d, "post_rst");
            rst[d] = 1'b0;
            idle_cycles(d, mf + 10);
            return;
         end
      end
      @(negedge clk);
      chk_idle(d, $sformatf("end w%0h", w));
      if (!keep) cmd_valid[d] = 1'b0;
   endtask

   initial begin
      logic [9:0] w;
      logic [7:0] r;
      bit         keep;
      bit         noise;
      n_chk  = 0;
      n_pass = 0;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; cmd_valid[d] = 1'b0; cmd_data[d] = '0; miso[d] = 1'b0;
         exp_rsp[d] = 8'h00;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk_idle(d, "reset");
         rst[d] = 1'b0;
      end

      for (int d = 0; d < 2; d++) begin
         run_frame(d, 10'h0A5, 8'h00, 1'b1, 1'b0, -1);
         run_frame(d, 10'h1C3, 8'h00, 1'b0, 1'b0, -1);
         idle_cycles(d, 2);
         run_frame(d, 10'h2A5, 8'h00, 1'b1, 1'b0, -1);
         run_frame(d, 10'h300, 8'h96, 1'b0, 1'b1, -1);
         idle_cycles(d, 3);
         run_frame(d, 10'h0F0, 8'h00, 1'b0, 1'b0, 5);
         run_frame(d, 10'h13C, 8'h00, 1'b0, 1'b0, -1);
         run_frame(d, 10'h3FF, 8'h5A, 1'b0, 1'b0, MF_TAB[d] + 4);
         run_frame(d, 10'h301, 8'hE1, 1'b0, 1'b0, -1);
         for (int i = 0; i < 24; i++) begin
            w     = 10'($urandom);
            r     = 8'($urandom);
            keep  = 1'($urandom_range(0, 1));
            noise = 1'($urandom_range(0, 1));
            run_frame(d, w, r, keep, noise, -1);
            if ($urandom_range(0, 3) == 0) idle_cycles(d, $urandom_range(1, 3));
         end
         idle_cycles(d, 2);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
